// File: rtl/nf10_axis_pkg.sv
// nf10_axis_pkg
//   Shared constants and helpers for the NF10 AXI-Stream width converters
//   (TX 256->64 downsizer, RX 64->256 packer).
//   NF10_AXIS_RATIO : number of 64-bit lanes in one 256-bit word
//   lane_t          : lane index type
//   strb_final_lane : lane occupancy mask -> highest occupied lane (0 if none)
//   ST_EMPTY/ST_EMIT: downsizer state encoding
package nf10_axis_pkg;

  localparam int NF10_AXIS_RATIO = 4;
  localparam int NF10_LANE_W     = $clog2(NF10_AXIS_RATIO);

  typedef logic [NF10_LANE_W-1:0] lane_t;

  localparam logic [0:0] ST_EMPTY = 1'b0;  // no word held, output idle
  localparam logic [0:0] ST_EMIT  = 1'b1;  // word held, lanes being emitted

  // Highest lane whose occupancy bit is set; an empty mask maps to lane 0 so
  // a zero-strobe last word still yields exactly one terminator beat.
  function automatic lane_t strb_final_lane(input logic [NF10_AXIS_RATIO-1:0] lane_any);
    lane_t r;
    r = '0;
    for (int k = 0; k < NF10_AXIS_RATIO; k++)
      if (lane_any[k]) r = lane_t'(k);
    return r;
  endfunction

endpackage

// File: rtl/nf10_axis_tx_downsizer_if.sv
// nf10_axis_tx_downsizer_if
//   AXI-Stream bundle used on both sides of the TX downsizer.
//   Parameters: DATA_W (tdata width), USER_W (tuser width); tstrb is DATA_W/8.
//   Signals: tdata, tstrb, tuser, tvalid, tlast (source->sink), tready (sink->source).
//   Modports: master (drives the stream), slave (receives the stream).
interface nf10_axis_tx_downsizer_if #(
  parameter int DATA_W = 256,
  parameter int USER_W = 128
);
  logic [DATA_W-1:0]   tdata;
  logic [DATA_W/8-1:0] tstrb;
  logic [USER_W-1:0]   tuser;
  logic                tvalid;
  logic                tready;
  logic                tlast;

  modport master (output tdata, tstrb, tuser, tvalid, tlast, input  tready);
  modport slave  (input  tdata, tstrb, tuser, tvalid, tlast, output tready);
endinterface

// File: rtl/nf10_strb_last_lane.sv
// nf10_strb_last_lane
//   Combinational: reduces a wide byte-strobe vector to per-lane occupancy and
//   reports the highest non-empty lane plus an all-zero flag.
//   Ports:
//     tstrb     in  STRB_W        byte strobes of one wide word
//     last_lane out lane_t        highest lane with any strobe set (0 if none)
//     all_zero  out 1             no strobe bit set at all
module nf10_strb_last_lane
  import nf10_axis_pkg::*;
#(
  parameter int STRB_W = 32
) (
  input  logic [STRB_W-1:0] tstrb,
  output lane_t             last_lane,
  output logic              all_zero
);
  localparam int LANE_B = STRB_W / NF10_AXIS_RATIO;

  logic [NF10_AXIS_RATIO-1:0] lane_any;

  for (genvar k = 0; k < NF10_AXIS_RATIO; k++) begin : g_lane
    assign lane_any[k] = |tstrb[k*LANE_B +: LANE_B];
  end

  assign last_lane = strb_final_lane(lane_any);
  assign all_zero  = ~|lane_any;
endmodule

// File: rtl/nf10_axis_tx_downsizer.sv
// nf10_axis_tx_downsizer
//   TX width converter: 256-bit AXI-Stream words from the datapath are
//   serialised into 64-bit beats for the MAC. Non-last words always produce
//   4 beats with strobes passed through; the last word of a packet stops at
//   its highest non-empty lane (lane 0 with zero strobes if the word is
//   empty). tuser from the first word is held for the whole output packet.
//   Ports:
//     axi_aclk   in      clock
//     axi_reset  in      synchronous active-high reset
//     s_axis     slave   256-bit input stream (tdata/tstrb/tuser/tvalid/tlast, tready out)
//     m_axis     master  64-bit output stream (registered outputs)
//   Optional (macro NF10_TX_DOWNSIZER_STATS_EN):
//     pkt_count  out 32  count of output beats accepted with tlast
//     beat_count out 32  count of output beats accepted
//   Widths: C_S_AXIS_DATA_WIDTH must be 4*C_M_AXIS_DATA_WIDTH and the tuser
//   widths must match; the interfaces must be instantiated with these widths.
module nf10_axis_tx_downsizer
  import nf10_axis_pkg::*;
#(
  parameter int C_S_AXIS_DATA_WIDTH  = 256,
  parameter int C_M_AXIS_DATA_WIDTH  = 64,
  parameter int C_S_AXIS_TUSER_WIDTH = 128,
  parameter int C_M_AXIS_TUSER_WIDTH = 128
) (
  input  logic                     axi_aclk,
  input  logic                     axi_reset,
  nf10_axis_tx_downsizer_if.slave  s_axis,
  nf10_axis_tx_downsizer_if.master m_axis
`ifdef NF10_TX_DOWNSIZER_STATS_EN
  ,
  output logic [31:0]              pkt_count,
  output logic [31:0]              beat_count
`endif
);
  localparam int SW = C_S_AXIS_DATA_WIDTH / 8;
  localparam int MW = C_M_AXIS_DATA_WIDTH / 8;

  // input word viewed lane by lane
  logic [NF10_AXIS_RATIO-1:0][C_M_AXIS_DATA_WIDTH-1:0] s_words;
  logic [NF10_AXIS_RATIO-1:0][MW-1:0]                  s_strbs;

  // held word
  logic [0:0]                                          state;
  logic [NF10_AXIS_RATIO-1:0][C_M_AXIS_DATA_WIDTH-1:0] hold_data;
  logic [NF10_AXIS_RATIO-1:0][MW-1:0]                  hold_strb;
  logic                                                hold_last;
  lane_t                                               hold_final;
  lane_t                                               lane;
  logic                                                sop;

  // registered outputs
  logic [C_M_AXIS_DATA_WIDTH-1:0]  m_tdata;
  logic [MW-1:0]                   m_tstrb;
  logic [C_M_AXIS_TUSER_WIDTH-1:0] m_tuser;
  logic                            m_tvalid;
  logic                            m_tlast;

  logic  m_hs, s_hs, s_rdy, final_lane;
  lane_t lane_nxt, in_last_lane, in_final;
  logic  in_all_zero;

  assign s_words = s_axis.tdata;
  assign s_strbs = s_axis.tstrb;

  nf10_strb_last_lane #(.STRB_W(SW)) u_last_lane (
    .tstrb     (s_axis.tstrb),
    .last_lane (in_last_lane),
    .all_zero  (in_all_zero)
  );

  // Non-last words are never trimmed; an empty last word still emits lane 0.
  assign in_final = !s_axis.tlast ? lane_t'(NF10_AXIS_RATIO-1) :
                    in_all_zero   ? lane_t'(0) : in_last_lane;

  assign m_hs       = m_tvalid & m_axis.tready;
  assign final_lane = (lane == hold_final);
  assign lane_nxt   = lane + lane_t'(1);
  // Accept a new word when idle, or on the very edge the current word's
  // final lane is taken, so consecutive words stream without a bubble.
  assign s_rdy      = (state == ST_EMPTY) | (m_hs & final_lane);
  assign s_hs       = s_axis.tvalid & s_rdy;

  assign s_axis.tready = s_rdy;
  assign m_axis.tdata  = m_tdata;
  assign m_axis.tstrb  = m_tstrb;
  assign m_axis.tuser  = m_tuser;
  assign m_axis.tvalid = m_tvalid;
  assign m_axis.tlast  = m_tlast;

  always_ff @(posedge axi_aclk) begin
    if (axi_reset) begin
      state      <= ST_EMPTY;
      hold_data  <= '0;
      hold_strb  <= '0;
      hold_last  <= 1'b0;
      hold_final <= '0;
      lane       <= '0;
      sop        <= 1'b1;
      m_tdata    <= '0;
      m_tstrb    <= '0;
      m_tuser    <= '0;
      m_tvalid   <= 1'b0;
      m_tlast    <= 1'b0;
    end else if (s_hs) begin
      // lane 0 goes straight to the output; the full word is kept for lanes 1..3
      state      <= ST_EMIT;
      hold_data  <= s_words;
      hold_strb  <= s_strbs;
      hold_last  <= s_axis.tlast;
      hold_final <= in_final;
      lane       <= '0;
      sop        <= s_axis.tlast;
      m_tvalid   <= 1'b1;
      m_tdata    <= s_words[0];
      m_tstrb    <= s_strbs[0];
      m_tlast    <= s_axis.tlast & (in_final == lane_t'(0));
      if (sop) m_tuser <= s_axis.tuser;
    end else if (m_hs) begin
      if (final_lane) begin
        state    <= ST_EMPTY;
        m_tvalid <= 1'b0;
        m_tlast  <= 1'b0;
      end else begin
        lane     <= lane_nxt;
        m_tdata  <= hold_data[lane_nxt];
        m_tstrb  <= hold_strb[lane_nxt];
        m_tlast  <= hold_last & (lane_nxt == hold_final);
      end
    end
  end

`ifdef NF10_TX_DOWNSIZER_STATS_EN
  always_ff @(posedge axi_aclk) begin
    if (axi_reset) begin
      pkt_count  <= '0;
      beat_count <= '0;
    end else if (m_hs) begin
      beat_count <= beat_count + 32'd1;
      if (m_tlast) pkt_count <= pkt_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_nf10_axis_tx_downsizer.sv
module tb_nf10_axis_tx_downsizer;

  logic axi_aclk = 1'b0;
  logic axi_reset;
  always #5 axi_aclk = ~axi_aclk;

  nf10_axis_tx_downsizer_if #(.DATA_W(256), .USER_W(128)) s_if ();
  nf10_axis_tx_downsizer_if #(.DATA_W(64),  .USER_W(128)) m_if ();

`ifdef NF10_TX_DOWNSIZER_STATS_EN
  logic [31:0] pkt_count, beat_count;
`endif

  nf10_axis_tx_downsizer dut (
    .axi_aclk   (axi_aclk),
    .axi_reset  (axi_reset),
    .s_axis     (s_if),
    .m_axis     (m_if)
`ifdef NF10_TX_DOWNSIZER_STATS_EN
    ,
    .pkt_count  (pkt_count),
    .beat_count (beat_count)
`endif
  );

  typedef struct packed {
    logic [63:0]  d;
    logic [7:0]   s;
    logic         l;
    logic [127:0] u;
  } beat_t;

  beat_t exp_q[$];

  int n_chk = 0;
  int n_fail = 0;
  int beats_seen = 0;
  bit mon_en = 0;
  bit rand_rdy = 0;
  bit s_gaps = 0;
  bit prev_stall = 0;
  logic [255:0] prev_vec;

  // current packet being built / sent
  int           pkt_n;
  logic [255:0] pkt_data [4];
  logic [31:0]  pkt_strb [4];
  logic [127:0] pkt_user;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [255:0] rand256();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  // Reference: every non-last word yields 4 beats; the last word yields beats
  // up to the byte-highest set strobe (one beat if no strobe is set).
  task automatic model_push();
    beat_t b;
    int nl, top;
    for (int w = 0; w < pkt_n; w++) begin
      nl = 4;
      if (w == pkt_n - 1) begin
        top = 0;
        for (int k = 0; k < 32; k++) if (pkt_strb[w][k]) top = k / 8;
        nl = top + 1;
      end
      for (int k = 0; k < nl; k++) begin
        b.d = pkt_data[w][64*k +: 64];
        b.s = pkt_strb[w][8*k +: 8];
        b.l = (w == pkt_n - 1) && (k == nl - 1);
        b.u = pkt_user;
        exp_q.push_back(b);
      end
    end
  endtask

  task automatic send_pkt();
    bit hs;
    int c;
    model_push();
    for (int w = 0; w < pkt_n; w++) begin
      s_if.tdata  = pkt_data[w];
      s_if.tstrb  = pkt_strb[w];
      s_if.tlast  = (w == pkt_n - 1);
      s_if.tuser  = (w == 0) ? pkt_user : rand256()[127:0];
      s_if.tvalid = 1'b1;
      c = 0;
      do begin
        @(negedge axi_aclk);
        hs = s_if.tready;
        @(posedge axi_aclk); #1;
        c++;
      end while (!hs && c < 2000);
      if (!hs) check("s_handshake_timeout", 0, 1);
      s_if.tvalid = 1'b0;
      if (s_gaps && $urandom_range(0, 3) == 0) begin
        @(posedge axi_aclk); #1;
      end
    end
  endtask

  task automatic mk_full(input int n);
    pkt_n = n;
    pkt_user = rand256()[127:0];
    for (int w = 0; w < 4; w++) begin
      pkt_data[w] = rand256();
      pkt_strb[w] = 32'hFFFF_FFFF;
    end
  endtask

  task automatic mk_rand();
    int len;
    mk_full($urandom_range(1, 4));
    for (int w = 0; w < pkt_n - 1; w++)
      if ($urandom_range(0, 7) == 0) pkt_strb[w] = $urandom;
    case ($urandom_range(0, 3))
      0: pkt_strb[pkt_n-1] = 32'hFFFF_FFFF;
      1: pkt_strb[pkt_n-1] = 32'h0;
      2: begin
        len = $urandom_range(1, 31);
        pkt_strb[pkt_n-1] = (32'h1 << len) - 32'h1;
      end
      default: pkt_strb[pkt_n-1] = $urandom;
    endcase
  endtask

  task automatic wait_drain();
    int c = 0;
    while ((exp_q.size() != 0 || m_if.tvalid) && c < 5000) begin
      @(posedge axi_aclk); #1;
      c++;
    end
    check("drain", {255'd0, (exp_q.size() == 0 && !m_if.tvalid)}, 1);
  endtask

  always @(posedge axi_aclk) begin
    #1;
    m_if.tready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // Output monitor: scoreboard on every handshake, stability while stalled.
  always @(negedge axi_aclk) begin
    beat_t e;
    logic [255:0] cur;
    if (mon_en) begin
      cur = {54'd0, m_if.tdata, m_if.tstrb, m_if.tlast, m_if.tuser, m_if.tvalid};
      if (prev_stall) check("stable_while_stalled", cur, prev_vec);
      if (m_if.tvalid && m_if.tready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_beat", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("tdata", m_if.tdata, e.d);
          check("tstrb", m_if.tstrb, e.s);
          check("tlast", m_if.tlast, e.l);
          check("tuser", m_if.tuser, e.u);
        end
        beats_seen++;
      end
      prev_stall = m_if.tvalid && !m_if.tready;
      prev_vec   = cur;
    end
  end

  initial begin
    int b0, c, nv;
    axi_reset   = 1'b1;
    s_if.tvalid = 1'b0;
    s_if.tdata  = '0;
    s_if.tstrb  = '0;
    s_if.tuser  = '0;
    s_if.tlast  = 1'b0;
    m_if.tready = 1'b1;
    repeat (3) @(posedge axi_aclk);
    #1;
    axi_reset = 1'b0;

    // reset state
    check("rst_tvalid", m_if.tvalid, 0);
    check("rst_tlast",  m_if.tlast, 0);
    check("rst_tdata",  m_if.tdata, 0);
    check("rst_tstrb",  m_if.tstrb, 0);
    check("rst_tuser",  m_if.tuser, 0);
    check("rst_s_tready", s_if.tready, 1);
    mon_en = 1;

    // 64B packet, two full words
    b0 = beats_seen;
    mk_full(2);
    send_pkt();
    wait_drain();
    check("b64_beats", beats_seen - b0, 8);

    // 60B packet: last lane carries 4 bytes
    b0 = beats_seen;
    mk_full(2);
    pkt_strb[1] = 32'h0FFF_FFFF;
    send_pkt();
    wait_drain();
    check("b60_beats", beats_seen - b0, 8);

    // last word only fills lane 0
    b0 = beats_seen;
    mk_full(2);
    pkt_strb[1] = 32'h0000_00FF;
    send_pkt();
    wait_drain();
    check("lane0_only_beats", beats_seen - b0, 5);

    // zero-strobe last word -> single terminator beat
    b0 = beats_seen;
    mk_full(1);
    pkt_strb[0] = 32'h0;
    send_pkt();
    wait_drain();
    check("zero_len_beats", beats_seen - b0, 1);

    // back-to-back packets: 16 beats with no idle cycle
    nv = 0;
    fork
      begin
        mk_full(2); send_pkt();
        mk_full(2); send_pkt();
      end
      begin
        c = 0;
        do begin @(negedge axi_aclk); c++; end while (!m_if.tvalid && c < 100);
        nv = m_if.tvalid ? 1 : 0;
        repeat (15) begin
          @(negedge axi_aclk);
          if (m_if.tvalid) nv++;
        end
      end
    join
    check("b2b_no_bubble", nv, 16);
    wait_drain();

    // random backpressure and random packet shapes
    rand_rdy = 1;
    s_gaps   = 1;
    for (int p = 0; p < 1000; p++) begin
      mk_rand();
      send_pkt();
    end
    wait_drain();
    rand_rdy = 0;
    s_gaps   = 0;
    @(posedge axi_aclk); #1;

    // reset in the middle of a packet, after two output beats
    mon_en = 0;
    mk_full(2);
    s_if.tdata = pkt_data[0]; s_if.tstrb = pkt_strb[0];
    s_if.tuser = pkt_user;    s_if.tlast = 1'b0;
    s_if.tvalid = 1'b1;
    @(posedge axi_aclk); #1;
    s_if.tdata = pkt_data[1]; s_if.tstrb = pkt_strb[1]; s_if.tlast = 1'b1;
    @(posedge axi_aclk); #1;
    @(posedge axi_aclk); #1;
    check("mid_pkt_lane2_valid", m_if.tvalid, 1);
    check("mid_pkt_lane2_data", m_if.tdata, pkt_data[0][191:128]);
    axi_reset   = 1'b1;
    s_if.tvalid = 1'b0;
    @(posedge axi_aclk); #1;
    axi_reset = 1'b0;
    check("mid_rst_tvalid", m_if.tvalid, 0);
    check("mid_rst_tlast",  m_if.tlast, 0);
    check("mid_rst_s_tready", s_if.tready, 1);
    exp_q.delete();
    prev_stall = 0;
    mon_en = 1;

    // clean packet after the reset
    b0 = beats_seen;
    mk_full(2);
    pkt_strb[1] = 32'h00FF_FFFF;
    send_pkt();
    wait_drain();
    check("post_rst_beats", beats_seen - b0, 7);

    repeat (2) @(posedge axi_aclk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
